apb_master_arb: RTL and testbench



---
 rtl/apb_master_arb_if.sv | 54 +++++
 rtl/apb_master_arb.sv | 182 ++++++++++++++++++
 tb/tb_apb_master_arb.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_arb_if
// Purpose  : Requester and APB-bus bundle for the two-port APB master arbiter.
// Revision : 1.0
// ============================================================================
interface apb_master_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              m0_req;
    logic              m0_rw;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_done;
    logic              m0_err;

    logic              m1_req;
    logic              m1_rw;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_done;
    logic              m1_err;

    logic              apb_valid;
    logic              apb_psel;
    logic              apb_enab;
    logic              apb_rw;
    logic [ADDR_W-1:0] apb_addr;
    logic [DATA_W-1:0] apb_datai;
    logic [DATA_W-1:0] apb_datao;
    logic              apb_ack;

    modport master (
        input  m0_req, m0_rw, m0_addr, m0_wdata,
        output m0_rdata, m0_done, m0_err,
        input  m1_req, m1_rw, m1_addr, m1_wdata,
        output m1_rdata, m1_done, m1_err,
        output apb_valid, apb_psel, apb_enab, apb_rw, apb_addr, apb_datai,
        input  apb_datao, apb_ack
    );

    modport slave (
        output m0_req, m0_rw, m0_addr, m0_wdata,
        input  m0_rdata, m0_done, m0_err,
        output m1_req, m1_rw, m1_addr, m1_wdata,
        input  m1_rdata, m1_done, m1_err,
        input  apb_valid, apb_psel, apb_enab, apb_rw, apb_addr, apb_datai,
        output apb_datao, apb_ack
    );
endinterface
`default_nettype wire

// File: rtl/apb_master_arb.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_arb
// Purpose  : Round-robin two-requester APB master; ACCESS timeout is enabled
//            by defining APB_ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module apb_master_arb #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  wire logic        clk,
    input  wire logic        resetn,
    apb_master_arb_if.master bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    if (TIMEOUT < 1) begin : g_timeout_range_check
        $error("apb_master_arb: TIMEOUT must be at least 1");
    end

    state_t            r_state, w_state_nxt;
    logic              r_grant, w_grant_nxt;
    logic              r_last_grant, w_last_grant_nxt;
    logic              r_psel, w_psel_nxt;
    logic              r_enab, w_enab_nxt;
    logic              r_rw, w_rw_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_datai, w_datai_nxt;
    logic [DATA_W-1:0] r_rdata0, w_rdata0_nxt;
    logic [DATA_W-1:0] r_rdata1, w_rdata1_nxt;
    logic [1:0]        r_done, w_done_nxt;
    logic              w_timeout;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int                 c_CNT_W    = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]         r_err, w_err_nxt;

    // The count equals the number of ack-less ACCESS cycles already elapsed.
    assign w_timeout = (r_state == ACCESS) && (r_cnt == c_CNT_LAST);

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_err_nxt = 2'b00;
        if (r_state == SETUP) begin
            w_cnt_nxt = '0;
        end else if (r_state == ACCESS && !bus.apb_ack) begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (w_timeout) begin
                w_err_nxt[r_grant] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt <= '0;
            r_err <= 2'b00;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_err <= w_err_nxt;
        end
    end

    assign bus.m0_err = r_err[0];
    assign bus.m1_err = r_err[1];
`else
    assign w_timeout  = 1'b0;
    assign bus.m0_err = 1'b0;
    assign bus.m1_err = 1'b0;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        w_psel_nxt       = 1'b0;
        w_enab_nxt       = 1'b0;
        w_rw_nxt         = 1'b0;
        w_addr_nxt       = '0;
        w_datai_nxt      = '0;
        w_rdata0_nxt     = '0;
        w_rdata1_nxt     = '0;
        w_done_nxt       = 2'b00;
        case (r_state)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    // Under contention the requester not served last time wins.
                    w_grant_nxt      = (bus.m0_req && bus.m1_req) ? ~r_last_grant : bus.m1_req;
                    w_last_grant_nxt = w_grant_nxt;
                    w_state_nxt      = SETUP;
                    w_psel_nxt       = 1'b1;
                    w_rw_nxt         = w_grant_nxt ? bus.m1_rw    : bus.m0_rw;
                    w_addr_nxt       = w_grant_nxt ? bus.m1_addr  : bus.m0_addr;
                    w_datai_nxt      = w_grant_nxt ? bus.m1_wdata : bus.m0_wdata;
                end
            end
            SETUP: begin
                w_state_nxt = ACCESS;
                w_psel_nxt  = 1'b1;
                w_enab_nxt  = 1'b1;
                w_rw_nxt    = r_rw;
                w_addr_nxt  = r_addr;
                w_datai_nxt = r_datai;
            end
            ACCESS: begin
                if (bus.apb_ack || w_timeout) begin
                    w_state_nxt         = DONE;
                    w_done_nxt[r_grant] = 1'b1;
                    if (bus.apb_ack && !r_rw) begin
                        if (r_grant) begin
                            w_rdata1_nxt = bus.apb_datao;
                        end else begin
                            w_rdata0_nxt = bus.apb_datao;
                        end
                    end
                end else begin
                    w_psel_nxt  = 1'b1;
                    w_enab_nxt  = 1'b1;
                    w_rw_nxt    = r_rw;
                    w_addr_nxt  = r_addr;
                    w_datai_nxt = r_datai;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_psel       <= 1'b0;
            r_enab       <= 1'b0;
            r_rw         <= 1'b0;
            r_addr       <= '0;
            r_datai      <= '0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
            r_done       <= 2'b00;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_psel       <= w_psel_nxt;
            r_enab       <= w_enab_nxt;
            r_rw         <= w_rw_nxt;
            r_addr       <= w_addr_nxt;
            r_datai      <= w_datai_nxt;
            r_rdata0     <= w_rdata0_nxt;
            r_rdata1     <= w_rdata1_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign bus.apb_valid = r_psel;
    assign bus.apb_psel  = r_psel;
    assign bus.apb_enab  = r_enab;
    assign bus.apb_rw    = r_rw;
    assign bus.apb_addr  = r_addr;
    assign bus.apb_datai = r_datai;
    assign bus.m0_rdata  = r_rdata0;
    assign bus.m1_rdata  = r_rdata1;
    assign bus.m0_done   = r_done[0];
    assign bus.m1_done   = r_done[1];
endmodule
`default_nettype wire

// File: tb/tb_apb_master_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_arb
// Purpose  : Self-checking bench for apb_master_arb (APB_ARB_TIMEOUT_EN aware).
// Revision : 1.0
// ============================================================================
module tb_apb_master_arb;
    localparam int c_AW = 32;
    localparam int c_DW = 32;
`ifdef APB_ARB_TIMEOUT_EN
    localparam int c_TO = 4;
`else
    localparam int c_TO = 255;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;

    apb_master_arb_if #(.ADDR_W(c_AW), .DATA_W(c_DW)) bus ();

    apb_master_arb #(.ADDR_W(c_AW), .DATA_W(c_DW), .TIMEOUT(c_TO)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int dut_done_n = 0;
    int mdl_done_n = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transfer-level model: a transfer is described by its grant cycle and
    // the cycle its done pulse appears; every output follows from those.
    typedef struct {
        bit          active;
        bit          g;
        bit          last;
        int          gc;
        int          dc;
        bit          err;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] cap;
        logic        psel;
        logic        enab;
        logic        orw;
        logic [31:0] oaddr;
        logic [31:0] odatai;
        logic [1:0]  done;
        logic [1:0]  oerr;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } model_t;

    model_t m;

    function automatic model_t step(input model_t s, input int c);
        model_t n = s;
        if (!resetn) begin
            n.active = 1'b0;
            n.last   = 1'b1;
            n.dc     = 0;
        end else if (n.active) begin
            if (n.dc != 0 && n.dc == c - 1) begin
                n.active = 1'b0;
            end else if (n.dc == 0 && c - 1 >= n.gc + 2) begin
                if (bus.apb_ack) begin
                    n.dc  = c;
                    n.err = 1'b0;
                    n.cap = n.rw ? 32'h0 : bus.apb_datao;
                end
`ifdef APB_ARB_TIMEOUT_EN
                else if ((c - 1) - (n.gc + 2) + 1 == c_TO) begin
                    n.dc  = c;
                    n.err = 1'b1;
                    n.cap = 32'h0;
                end
`endif
            end
        end else if (bus.m0_req || bus.m1_req) begin
            n.g      = (bus.m0_req && bus.m1_req) ? !n.last : bus.m1_req;
            n.last   = n.g;
            n.active = 1'b1;
            n.gc     = c - 1;
            n.dc     = 0;
            n.rw     = n.g ? bus.m1_rw    : bus.m0_rw;
            n.addr   = n.g ? bus.m1_addr  : bus.m0_addr;
            n.wdata  = n.g ? bus.m1_wdata : bus.m0_wdata;
        end
        n.psel = 1'b0; n.enab = 1'b0; n.orw = 1'b0; n.oaddr = '0; n.odatai = '0;
        n.done = 2'b00; n.oerr = 2'b00; n.rd0 = '0; n.rd1 = '0;
        if (n.active) begin
            if (n.dc == c) begin
                n.done[n.g] = 1'b1;
                n.oerr[n.g] = n.err;
                if (n.g) n.rd1 = n.cap;
                else     n.rd0 = n.cap;
            end else begin
                n.psel   = 1'b1;
                n.enab   = (c - n.gc >= 2);
                n.orw    = n.rw;
                n.oaddr  = n.addr;
                n.odatai = n.wdata;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m   <= step(m, cyc + 1);
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk("apb_psel",  bus.apb_psel,  m.psel);
            chk("apb_valid", bus.apb_valid, m.psel);
            chk("apb_enab",  bus.apb_enab,  m.enab);
            chk("apb_rw",    bus.apb_rw,    m.orw);
            chk("apb_addr",  bus.apb_addr,  m.oaddr);
            chk("apb_datai", bus.apb_datai, m.odatai);
            chk("m0_done",   bus.m0_done,   m.done[0]);
            chk("m1_done",   bus.m1_done,   m.done[1]);
            if (m.done[0]) begin
                chk("m0_rdata", bus.m0_rdata, m.rd0);
                chk("m0_err",   bus.m0_err,   m.oerr[0]);
            end
            if (m.done[1]) begin
                chk("m1_rdata", bus.m1_rdata, m.rd1);
                chk("m1_err",   bus.m1_err,   m.oerr[1]);
            end
            dut_done_n += int'(bus.m0_done) + int'(bus.m1_done);
            mdl_done_n += int'(m.done[0]) + int'(m.done[1]);
        end
    end

    int ord[4];
    int ord_n;
    int exp_ord[4] = '{0, 1, 0, 1};
    bit seen;

    initial begin
        bus.m0_req = 0; bus.m0_rw = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 0; bus.m1_rw = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
        bus.apb_ack = 0; bus.apb_datao = '0;
        resetn = 0;
        repeat (2) @(negedge clk);
        chk("rst_psel", bus.apb_psel, 0);
        chk("rst_addr", bus.apb_addr, 0);
        chk("rst_done", {bus.m0_done, bus.m1_done, bus.m0_err, bus.m1_err}, 0);
        resetn = 1;
        @(negedge clk);

        // Single m0 read, immediate ack
        bus.m0_req = 1; bus.m0_rw = 0; bus.m0_addr = 32'h0000_1004;
        bus.apb_ack = 1; bus.apb_datao = 32'hA5A5_1234;
        @(negedge clk);
        chk("t1_psel_n1", bus.apb_psel, 1);
        chk("t1_enab_n1", bus.apb_enab, 0);
        @(negedge clk);
        chk("t1_enab_n2", bus.apb_enab, 1);
        chk("t1_addr_n2", bus.apb_addr, 32'h0000_1004);
        @(negedge clk);
        chk("t1_m0_done", bus.m0_done, 1);
        chk("t1_m0_rdata", bus.m0_rdata, 32'hA5A5_1234);
        chk("t1_m1_done", bus.m1_done, 0);
        chk("t1_model_rdata", m.rd0, 32'hA5A5_1234);
        bus.m0_req = 0;
        @(negedge clk);
        chk("t1_idle_psel", bus.apb_psel, 0);
        chk("t1_idle_done", bus.m0_done, 0);

        // m1 write with three wait states
        bus.m1_req = 1; bus.m1_rw = 1; bus.m1_addr = 32'h0000_2008; bus.m1_wdata = 32'hDEAD_BEEF;
        bus.apb_ack = 0;
        @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("t2_enab",  bus.apb_enab,  1);
            chk("t2_datai", bus.apb_datai, 32'hDEAD_BEEF);
            chk("t2_rw",    bus.apb_rw,    1);
            chk("t2_addr",  bus.apb_addr,  32'h0000_2008);
            if (k == 4) bus.apb_ack = 1;
        end
        @(negedge clk);
        chk("t2_m1_done", bus.m1_done, 1);
        chk("t2_m1_rdata", bus.m1_rdata, 0);
        chk("t2_m0_done", bus.m0_done, 0);
        chk("t2_model_done", m.done, 2'b10);
        bus.m1_req = 0;
        @(negedge clk);

        // Contention right after reset: m0 first, then alternate
        resetn = 0;
        repeat (2) @(negedge clk);
        resetn = 1;
        bus.m0_req = 1; bus.m0_rw = 0; bus.m0_addr = 32'h100;
        bus.m1_req = 1; bus.m1_rw = 1; bus.m1_addr = 32'h200; bus.m1_wdata = 32'h55;
        bus.apb_ack = 1; bus.apb_datao = 32'h0BAD_CAFE;
        ord_n = 0;
        for (int i = 0; i < 40 && ord_n < 4; i++) begin
            @(negedge clk);
            if (bus.m0_done && ord_n < 4) begin ord[ord_n] = 0; ord_n++; end
            if (bus.m1_done && ord_n < 4) begin ord[ord_n] = 1; ord_n++; end
            bus.m0_req = !m.done[0] && (bus.m0_req || ord_n < 3);
            bus.m1_req = !m.done[1] && (bus.m1_req || ord_n < 3);
        end
        chk("t3_grant_count", ord_n, 4);
        for (int i = 0; i < 4; i++) chk("t3_grant_order", ord[i], exp_ord[i]);
        bus.m0_req = 0; bus.m1_req = 0;
        repeat (2) @(negedge clk);

        // Reset during ACCESS, then re-request
        bus.m0_req = 1; bus.m0_rw = 0; bus.m0_addr = 32'h3000; bus.apb_ack = 0;
        repeat (2) @(negedge clk);
        chk("t4_in_access", bus.apb_enab, 1);
        resetn = 0;
        @(negedge clk);
        chk("t4_rst_bus", {bus.apb_psel, bus.apb_enab, bus.apb_rw}, 0);
        chk("t4_rst_addr", bus.apb_addr, 0);
        chk("t4_rst_done", bus.m0_done, 0);
        resetn = 1; bus.apb_ack = 1; bus.apb_datao = 32'h1234_5678;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.m0_done) begin
                seen = 1;
                chk("t4_rdata", bus.m0_rdata, 32'h1234_5678);
            end
        end
        chk("t4_redone", seen, 1);
        bus.m0_req = 0;
        @(negedge clk);

`ifdef APB_ARB_TIMEOUT_EN
        // Slave never acks: timeout after TIMEOUT ACCESS cycles
        bus.m0_req = 1; bus.m0_rw = 0; bus.m0_addr = 32'h4000; bus.apb_ack = 0;
        @(negedge clk);
        for (int k = 1; k <= c_TO; k++) begin
            @(negedge clk);
            chk("t5_wait_done", bus.m0_done, 0);
        end
        @(negedge clk);
        chk("t5_done", bus.m0_done, 1);
        chk("t5_err", bus.m0_err, 1);
        chk("t5_rdata", bus.m0_rdata, 0);
        bus.m0_req = 0;
        @(negedge clk);
        // Ack on the limit cycle wins over timeout
        bus.m0_req = 1; bus.apb_datao = 32'hCAFE_F00D;
        @(negedge clk);
        for (int k = 1; k <= c_TO; k++) begin
            @(negedge clk);
            if (k == c_TO) bus.apb_ack = 1;
        end
        @(negedge clk);
        chk("t6_done", bus.m0_done, 1);
        chk("t6_err", bus.m0_err, 0);
        chk("t6_rdata", bus.m0_rdata, 32'hCAFE_F00D);
        bus.m0_req = 0; bus.apb_ack = 0;
        @(negedge clk);
`endif

        // Randomized traffic from both requesters
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus.apb_ack   = ($urandom_range(0, 3) != 0);
            bus.apb_datao = $urandom;
            if (bus.m0_req && m.done[0]) begin
                bus.m0_req = 0;
            end else if (!bus.m0_req && $urandom_range(0, 2) == 0) begin
                bus.m0_req = 1; bus.m0_rw = 1'($urandom_range(0, 1));
                bus.m0_addr = $urandom & 32'hFFFF_FFFC; bus.m0_wdata = $urandom;
            end
            if (bus.m1_req && m.done[1]) begin
                bus.m1_req = 0;
            end else if (!bus.m1_req && $urandom_range(0, 2) == 0) begin
                bus.m1_req = 1; bus.m1_rw = 1'($urandom_range(0, 1));
                bus.m1_addr = $urandom & 32'hFFFF_FFFC; bus.m1_wdata = $urandom;
            end
        end
        @(negedge clk);
        chk("done_count", dut_done_n, mdl_done_n);
        chk("progress", (dut_done_n > 100), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
